tcdm_rr_bank_arbiter: RTL and testbench
=======================================

TCDM_RR_BANK_ARBITER -- requirements
Module: tcdm_rr_bank_arbiter

Interface
REQ-001 SHALL have parameter NR_MASTER_PORTS, default 4, number of requesting TCDM masters sharing one slave port (1..32).
REQ-002 SHALL use fixed widths from the shared package: ADDR_WIDTH 32, DATA_WIDTH 32, BE_WIDTH 4; IDX_WIDTH = max(1, clog2(NR_MASTER_PORTS)).
REQ-003 SHALL operate on one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk_i, input, 1, clock.
REQ-005 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port master_req_i, input, [NR_MASTER_PORTS], per-master request.
REQ-007 SHALL have ports master_add_i / master_wen_i / master_wdata_i / master_be_i, input, [NR_MASTER_PORTS] x 32 / 1 / 32 / 4, per-master address, write-enable (active-low, 1 = read), write data and byte enables.
REQ-008 SHALL have port master_gnt_o, output, [NR_MASTER_PORTS], per-master grant.
REQ-009 SHALL have ports master_r_valid_o, output, [NR_MASTER_PORTS]; master_r_rdata_o, output, 32; master_r_opc_o, output, 1; response valid per master, broadcast read data and error flag.
REQ-010 SHALL have ports slave_req_o / slave_add_o / slave_wen_o / slave_wdata_o / slave_be_o, output, 1 / 32 / 1 / 32 / 4, request towards the shared slave port.
REQ-011 SHALL have ports slave_gnt_i, input, 1; slave_r_rdata_i, input, 32; slave_r_opc_i, input, 1; slave grant, and response one cycle after handshake.

Function
REQ-012 SHALL drive slave_req_o = OR of master_req_i, combinationally.
REQ-013 SHALL select winner w = first index i with master_req_i[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-014 SHALL mux add/wen/wdata/be of master w onto the slave outputs; when no request, slave outputs SHALL be 0.
REQ-015 SHALL assert master_gnt_o[w] = slave_gnt_i & slave_req_o; all other grants 0; at most one grant per cycle.
REQ-016 SHALL define handshake as slave_req_o & slave_gnt_i.
REQ-017 SHALL update ptr only on handshake: ptr <= w+1, wrapping N-1 -> 0; otherwise ptr holds.
REQ-018 SHALL make the winner combinational; a slave stall may see w change if a master between ptr and w raises req. This is legal TCDM behaviour; the slave does not rely on a stable request before grant.
REQ-019 SHALL register resp_vld_q <= handshake and resp_idx_q <= w every cycle, giving fixed response latency 1 for reads and writes (write response on).
REQ-020 SHALL drive master_r_valid_o[i] = resp_vld_q & (resp_idx_q == i).
REQ-021 SHALL pass master_r_rdata_o = slave_r_rdata_i and master_r_opc_o = slave_r_opc_i unregistered to all masters.
REQ-022 SHALL allow back-to-back handshakes each cycle; a response and a new grant in the same cycle are independent.
REQ-023 SHALL, with NR_MASTER_PORTS = 1, keep ptr at 0 and degenerate to a pass-through with a registered r_valid.

Reset
REQ-024 SHALL asynchronously clear ptr to 0, resp_vld_q to 0 and resp_idx_q to 0 on rst_ni low.
REQ-025 SHALL hold all master_r_valid_o at 0 while in reset and in the first cycle after reset.
REQ-026 SHALL drop a response pending when reset asserts mid-operation, with no r_valid issued for it.

Structure
REQ-027 SHALL take ADDR_WIDTH, DATA_WIDTH, BE_WIDTH and a tcdm_req_t packed struct {wen, be, add, wdata} from the shared package pulp_soc_tcdm_pkg.
REQ-028 SHALL implement the rotating priority search in a single sub-module tcdm_rr_select (inputs req vector and ptr; outputs w and any_req).

Verification (N=4)
REQ-029 SHALL cover: after reset, only master 2 requests (read add 0x1C000008) with slave_gnt_i=1 -> master_gnt_o=0b0100 that cycle; next cycle master_r_valid_o=0b0100 with rdata=slave_r_rdata_i; ptr=3.
REQ-030 SHALL cover: all 4 masters request continuously with slave_gnt_i=1 -> grant order 0,1,2,3,0; one grant per cycle; each r_valid one cycle after its grant.
REQ-031 SHALL cover: masters 1 and 3 request, slave_gnt_i=0 for 3 cycles then 1 -> no grants and no r_valid during the stall; master 1 granted first (ptr=0), master 3 granted next cycle.
REQ-032 SHALL cover: ptr=3, masters 0 and 3 request -> master 3 wins; ptr wraps to 0; master 0 wins next.
REQ-033 SHALL cover: a write handshake (wen=0, be=0xF) with slave_r_opc_i=1 next cycle -> r_valid set for that master with r_opc=1.
REQ-034 SHALL cover: rst_ni dropped the cycle after a handshake -> r_valid stays 0; after release ptr=0 and master 0 wins a 4-way request.

Source files
------------

// File: rtl/pulp_soc_tcdm_pkg.sv
// Shared TCDM definitions: bus widths, the request bundle layout and a
// helper for sizing master index fields.
package pulp_soc_tcdm_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned BE_WIDTH   = 4;

    // One master's request payload as it travels towards the slave port.
    typedef struct packed {
        logic                  wen;    // active-low write enable, 1 = read
        logic [BE_WIDTH-1:0]   be;
        logic [ADDR_WIDTH-1:0] add;
        logic [DATA_WIDTH-1:0] wdata;
    } tcdm_req_t;

    // Width of an index that addresses n masters; never narrower than 1 bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tcdm_rr_select.sv
// Rotating-priority search: the winner is the first requesting index met
// when scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
module tcdm_rr_select
    import pulp_soc_tcdm_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned IDX_WIDTH = 2
) (
    input  logic [N-1:0]         req_i,
    input  logic [IDX_WIDTH-1:0] ptr_i,
    output logic [IDX_WIDTH-1:0] w_o,
    output logic                 any_req_o
);

    logic [IDX_WIDTH-1:0] w_hi;
    logic [IDX_WIDTH-1:0] w_lo;
    logic                 found_hi;

    // The lowest requester at or above ptr wins; otherwise the lowest one
    // below ptr (the wrapped part of the scan). Scanning downwards lets the
    // last assignment be the lowest index in each half.
    always_comb begin
        w_hi     = '0;
        w_lo     = '0;
        found_hi = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                if (IDX_WIDTH'(i) >= ptr_i) begin
                    w_hi     = IDX_WIDTH'(i);
                    found_hi = 1'b1;
                end else begin
                    w_lo     = IDX_WIDTH'(i);
                end
            end
        end
        w_o       = found_hi ? w_hi : w_lo;
        any_req_o = |req_i;
    end

endmodule

// File: rtl/tcdm_rr_bank_arbiter.sv
// Round-robin arbiter sharing one TCDM slave port among NR_MASTER_PORTS
// masters. The winner is combinational; the priority pointer only moves on
// a handshake. Responses come back exactly one cycle after the handshake
// and are steered to the master that was granted.
//
// Handshake: slave_req_o & slave_gnt_i in the same cycle transfers the
// winning master's request; the slave may stall by holding slave_gnt_i low,
// and the winner may change during a stall (legal TCDM behaviour).
module tcdm_rr_bank_arbiter
    import pulp_soc_tcdm_pkg::*;
#(
    parameter int unsigned NR_MASTER_PORTS = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,

    input  logic [NR_MASTER_PORTS-1:0] master_req_i,
    input  logic [ADDR_WIDTH-1:0]      master_add_i   [NR_MASTER_PORTS],
    input  logic                       master_wen_i   [NR_MASTER_PORTS],
    input  logic [DATA_WIDTH-1:0]      master_wdata_i [NR_MASTER_PORTS],
    input  logic [BE_WIDTH-1:0]        master_be_i    [NR_MASTER_PORTS],
    output logic [NR_MASTER_PORTS-1:0] master_gnt_o,

    output logic [NR_MASTER_PORTS-1:0] master_r_valid_o,
    output logic [DATA_WIDTH-1:0]      master_r_rdata_o,
    output logic                       master_r_opc_o,

    output logic                       slave_req_o,
    output logic [ADDR_WIDTH-1:0]      slave_add_o,
    output logic                       slave_wen_o,
    output logic [DATA_WIDTH-1:0]      slave_wdata_o,
    output logic [BE_WIDTH-1:0]        slave_be_o,
    input  logic                       slave_gnt_i,
    input  logic [DATA_WIDTH-1:0]      slave_r_rdata_i,
    input  logic                       slave_r_opc_i
);

    localparam int unsigned IDX_WIDTH = idx_width(NR_MASTER_PORTS);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NR_MASTER_PORTS - 1);

    logic [IDX_WIDTH-1:0] ptr_q;
    logic [IDX_WIDTH-1:0] winner;
    logic                 any_req;
    logic                 handshake;
    logic                 resp_vld_q;
    logic [IDX_WIDTH-1:0] resp_idx_q;

    tcdm_req_t            master_bundle [NR_MASTER_PORTS];
    tcdm_req_t            sel_bundle;

    tcdm_rr_select #(
        .N         (NR_MASTER_PORTS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_select (
        .req_i     (master_req_i),
        .ptr_i     (ptr_q),
        .w_o       (winner),
        .any_req_o (any_req)
    );

    // Bundle each master's payload so the slave mux is a single index.
    always_comb begin
        for (int i = 0; i < int'(NR_MASTER_PORTS); i++) begin
            master_bundle[i].wen   = master_wen_i[i];
            master_bundle[i].be    = master_be_i[i];
            master_bundle[i].add   = master_add_i[i];
            master_bundle[i].wdata = master_wdata_i[i];
        end
    end

    // Forward the winner's payload; an idle port shows all-zero fields.
    always_comb begin
        sel_bundle = '0;
        if (any_req) begin
            sel_bundle = master_bundle[winner];
        end
    end

    assign slave_req_o   = any_req;
    assign slave_add_o   = sel_bundle.add;
    assign slave_wen_o   = sel_bundle.wen;
    assign slave_wdata_o = sel_bundle.wdata;
    assign slave_be_o    = sel_bundle.be;

    assign handshake = slave_req_o & slave_gnt_i;

    // One-hot grant to the winner, only when the slave accepts.
    always_comb begin
        master_gnt_o = '0;
        for (int i = 0; i < int'(NR_MASTER_PORTS); i++) begin
            master_gnt_o[i] = handshake && (winner == IDX_WIDTH'(i));
        end
    end

    // Priority pointer moves just past the granted master on a handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (handshake) begin
            ptr_q <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
        end
    end

    // Remember every cycle whether a transfer happened and for whom; this
    // is the fixed one-cycle response tag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_vld_q <= 1'b0;
            resp_idx_q <= '0;
        end else begin
            resp_vld_q <= handshake;
            resp_idx_q <= winner;
        end
    end

    // Steer the response strobe to the tagged master; data is broadcast.
    always_comb begin
        master_r_valid_o = '0;
        for (int i = 0; i < int'(NR_MASTER_PORTS); i++) begin
            master_r_valid_o[i] = resp_vld_q && (resp_idx_q == IDX_WIDTH'(i));
        end
    end

    assign master_r_rdata_o = slave_r_rdata_i;
    assign master_r_opc_o   = slave_r_opc_i;

endmodule

// File: tb/tb_tcdm_rr_bank_arbiter.sv
// Bench for the round-robin TCDM bank arbiter with four masters: directed
// scenarios with literal expectations, then randomized traffic compared
// every cycle against a behavioural model of the arbitration rules.
module tb_tcdm_rr_bank_arbiter;
  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [N-1:0]  m_req;
  logic [31:0]   m_add   [N];
  logic          m_wen   [N];
  logic [31:0]   m_wdata [N];
  logic [3:0]    m_be    [N];
  logic [N-1:0]  m_gnt;
  logic [N-1:0]  m_rvalid;
  logic [31:0]   m_rdata;
  logic          m_ropc;
  logic          s_req;
  logic [31:0]   s_add;
  logic          s_wen;
  logic [31:0]   s_wdata;
  logic [3:0]    s_be;
  logic          s_gnt;
  logic [31:0]   s_rdata;
  logic          s_ropc;

  tcdm_rr_bank_arbiter #(.NR_MASTER_PORTS(N)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .master_req_i     (m_req),
    .master_add_i     (m_add),
    .master_wen_i     (m_wen),
    .master_wdata_i   (m_wdata),
    .master_be_i      (m_be),
    .master_gnt_o     (m_gnt),
    .master_r_valid_o (m_rvalid),
    .master_r_rdata_o (m_rdata),
    .master_r_opc_o   (m_ropc),
    .slave_req_o      (s_req),
    .slave_add_o      (s_add),
    .slave_wen_o      (s_wen),
    .slave_wdata_o    (s_wdata),
    .slave_be_o       (s_be),
    .slave_gnt_i      (s_gnt),
    .slave_r_rdata_i  (s_rdata),
    .slave_r_opc_i    (s_ropc)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge, then apply new inputs with
  // random payloads; callers may override individual fields afterwards.
  task automatic step(input logic [N-1:0] req, input logic gnt);
    @(posedge clk);
    #1;
    m_req = req;
    s_gnt = gnt;
    for (int i = 0; i < N; i++) begin
      m_add[i]   = $urandom;
      m_wen[i]   = 1'($urandom_range(0, 1));
      m_wdata[i] = $urandom;
      m_be[i]    = 4'($urandom_range(0, 15));
    end
    s_rdata = $urandom;
    s_ropc  = 1'($urandom_range(0, 1));
  endtask

  // Settle point for literal checks inside the cycle just driven.
  task automatic settle();
    #2;
  endtask

  // ---------------- behavioural model + compare process ----------------
  // Model: a priority pointer and a one-deep "response due next cycle" tag.
  int m_ptr = 0;
  int m_vld = 0;
  int m_idx = 0;

  always @(negedge clk) begin
    int w;
    int any;
    logic [N-1:0] exp_gnt;
    logic [N-1:0] exp_rv;
    if (!rst_n) begin
      check("rvalid_in_reset", 64'(m_rvalid), 64'(0));
      m_ptr = 0;
      m_vld = 0;
      m_idx = 0;
    end else begin
      any = (m_req != 0) ? 1 : 0;
      w = 0;
      for (int k = N - 1; k >= 0; k--) begin
        if (m_req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      exp_gnt = (any == 1 && s_gnt) ? N'(1 << w) : '0;
      exp_rv  = (m_vld == 1) ? N'(1 << m_idx) : '0;
      check("slave_req", 64'(s_req), 64'(any));
      check("slave_add", 64'(s_add), any == 1 ? 64'(m_add[w]) : 64'(0));
      check("slave_wen", 64'(s_wen), any == 1 ? 64'(m_wen[w]) : 64'(0));
      check("slave_wdata", 64'(s_wdata), any == 1 ? 64'(m_wdata[w]) : 64'(0));
      check("slave_be", 64'(s_be), any == 1 ? 64'(m_be[w]) : 64'(0));
      check("gnt", 64'(m_gnt), 64'(exp_gnt));
      check("r_valid", 64'(m_rvalid), 64'(exp_rv));
      check("r_rdata", 64'(m_rdata), 64'(s_rdata));
      check("r_opc", 64'(m_ropc), 64'(s_ropc));
      // State as it will be after the coming rising edge.
      m_vld = (exp_gnt != 0) ? 1 : 0;
      m_idx = w;
      if (exp_gnt != 0) m_ptr = (w + 1) % N;
    end
  end

  // ---------------- directed + random stimulus ----------------
  logic [N-1:0] exp_order [5];

  initial begin
    m_req = '0;
    s_gnt = 1'b0;
    s_rdata = '0;
    s_ropc = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_add[i] = '0; m_wen[i] = 1'b1; m_wdata[i] = '0; m_be[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // First cycle after reset: idle port, no response.
    step('0, 1'b1);
    settle();
    check("post_reset_rvalid", 64'(m_rvalid), 64'(0));
    check("post_reset_slave_add", 64'(s_add), 64'(0));

    // Lone read from master 2.
    step(4'b0100, 1'b1);
    m_add[2] = 32'h1C00_0008;
    m_wen[2] = 1'b1;
    settle();
    check("m2_gnt", 64'(m_gnt), 64'(4'b0100));
    check("m2_slave_add", 64'(s_add), 64'(32'h1C00_0008));
    step('0, 1'b0);
    settle();
    check("m2_rvalid", 64'(m_rvalid), 64'(4'b0100));
    check("m2_rdata", 64'(m_rdata), 64'(s_rdata));
    // Pointer now 3: a full request picks master 3.
    step(4'b1111, 1'b1);
    settle();
    check("ptr3_gnt", 64'(m_gnt), 64'(4'b1000));

    // Continuous 4-way contention: 0,1,2,3,0 with one-cycle responses.
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      step(4'b1111, 1'b1);
      settle();
      check("rr_gnt", 64'(m_gnt), 64'(exp_order[c]));
      check("rr_rvalid", 64'(m_rvalid), c == 0 ? 64'(4'b1000) : 64'(exp_order[c-1]));
    end

    // Stall with masters 1 and 3 pending, pointer at 0.
    step(4'b1000, 1'b1);   // master 3 only -> pointer returns to 0
    step('0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(4'b1010, 1'b0);
      settle();
      check("stall_gnt", 64'(m_gnt), 64'(0));
      check("stall_rvalid", 64'(m_rvalid), 64'(0));
    end
    step(4'b1010, 1'b1);
    settle();
    check("stall_release_gnt1", 64'(m_gnt), 64'(4'b0010));
    step(4'b1010, 1'b1);
    settle();
    check("stall_release_gnt3", 64'(m_gnt), 64'(4'b1000));
    check("stall_release_rv1", 64'(m_rvalid), 64'(4'b0010));

    // Wrap: pointer at 3 with masters 0 and 3 requesting.
    step(4'b0100, 1'b1);   // grant master 2 -> pointer 3
    step(4'b1001, 1'b1);
    settle();
    check("wrap_gnt3", 64'(m_gnt), 64'(4'b1000));
    step(4'b1001, 1'b1);
    settle();
    check("wrap_gnt0", 64'(m_gnt), 64'(4'b0001));

    // Write with error response.
    step(4'b0010, 1'b1);
    m_wen[1] = 1'b0;
    m_be[1] = 4'hF;
    settle();
    check("wr_gnt", 64'(m_gnt), 64'(4'b0010));
    check("wr_slave_wen", 64'(s_wen), 64'(0));
    step('0, 1'b0);
    s_ropc = 1'b1;
    settle();
    check("wr_rvalid", 64'(m_rvalid), 64'(4'b0010));
    check("wr_opc", 64'(m_ropc), 64'(1));

    // Reset right after a handshake drops the pending response.
    step(4'b0100, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    m_req = '0;
    settle();
    check("rst_drop_rvalid", 64'(m_rvalid), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(4'b1111, 1'b1);
    settle();
    check("rst_after_gnt0", 64'(m_gnt), 64'(4'b0001));
    check("rst_after_rvalid", 64'(m_rvalid), 64'(0));

    // Randomized traffic, occasional mid-run resets.
    for (int c = 0; c < 3000; c++) begin
      step(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
    end

    step('0, 1'b0);
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
